mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_rr_arbiter.sv | 45 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the instruction/data cache memory arbiter.
package mem_pkg;

   localparam int ADDR_W = 26;
   localparam int LINE_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } requester_t;

   // Forces a returned line to zero unless its qualifier is set.
   function automatic logic [LINE_W-1:0] gate_line(input logic en, input logic [LINE_W-1:0] data);
      if (en) begin
         gate_line = data;
      end else begin
         gate_line = {LINE_W{1'b0}};
      end
   endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// the requester that was not served most recently.
module mem_rr_arbiter
   import mem_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_req_ic,
   input  logic       i_req_dc,
   input  logic       i_take,
   output logic       o_valid,
   output requester_t o_grant
);

   requester_t r_last;

   // Choose the requester to serve this cycle.
   always_comb begin
      o_valid = i_req_ic | i_req_dc;
      o_grant = REQ_IC;
      if (i_req_ic && i_req_dc) begin
         if (r_last == REQ_DC) begin
            o_grant = REQ_IC;
         end else begin
            o_grant = REQ_DC;
         end
      end else if (i_req_dc) begin
         o_grant = REQ_DC;
      end else begin
         o_grant = REQ_IC;
      end
   end

   // Remember who was served last; after reset the instruction cache wins the first tie.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last <= REQ_DC;
      end else if (i_take) begin
         r_last <= o_grant;
      end else begin
         r_last <= r_last;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates line reads/writes from the instruction and data caches onto a
// single fixed-latency RAM port, one transaction in flight at a time.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int MEM_LATENCY = 5   // WAIT cycles per transaction, 1..15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_ack,
   output logic [LINE_W-1:0] ic_rdata,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic              dc_ack,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              mem_reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [LINE_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   state_t            r_state;
   logic [3:0]        r_cnt;
   requester_t        r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_wdata;
   logic              r_ic_ack;
   logic              r_dc_ack;
   logic              r_mem_we;
   logic              r_busy;

   logic              w_valid;
   requester_t        w_grant;
   logic              w_take;
   logic              w_live;

   assign w_take = (r_state == IDLE) && w_valid;

   mem_rr_arbiter u_rr (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_req_ic (ic_req),
      .i_req_dc (dc_req),
      .i_take   (w_take),
      .o_valid  (w_valid),
      .o_grant  (w_grant)
   );

   // Outputs are forced quiet in the reset cycle itself so an abandoned
   // transaction can never leak an ack or a write strobe.
   assign w_live    = ~reset;
   assign mem_reset = reset;
   assign ic_ack    = r_ic_ack & w_live;
   assign dc_ack    = r_dc_ack & w_live;
   assign mem_we    = r_mem_we & w_live;
   assign busy      = r_busy & w_live;
   assign mem_addr  = w_live ? r_addr : {ADDR_W{1'b0}};
   assign mem_waddr = mem_addr;
   assign mem_wdata = w_live ? r_wdata : {LINE_W{1'b0}};
   assign ic_rdata  = gate_line(ic_ack, mem_rdata);
   assign dc_rdata  = gate_line(dc_ack & ~r_we, mem_rdata);

   // Transaction FSM: latch the winner in IDLE, count out the RAM latency, pulse ack in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_owner  <= REQ_DC;
         r_we     <= 1'b0;
         r_addr   <= {ADDR_W{1'b0}};
         r_wdata  <= {LINE_W{1'b0}};
         r_ic_ack <= 1'b0;
         r_dc_ack <= 1'b0;
         r_mem_we <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_state <= WAIT;
                  r_cnt   <= LAT_M1;
                  r_owner <= w_grant;
                  r_busy  <= 1'b1;
                  if (w_grant == REQ_DC) begin
                     r_we    <= dc_we;
                     r_addr  <= dc_addr;
                     r_wdata <= dc_wdata;
                  end else begin
                     r_we    <= 1'b0;
                     r_addr  <= ic_addr;
                     r_wdata <= {LINE_W{1'b0}};
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state  <= DONE;
                  r_ic_ack <= (r_owner == REQ_IC);
                  r_dc_ack <= (r_owner == REQ_DC);
                  r_mem_we <= r_we;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            DONE: begin
               r_state  <= IDLE;
               r_ic_ack <= 1'b0;
               r_dc_ack <= 1'b0;
               r_mem_we <= 1'b0;
               r_busy   <= 1'b0;
               r_we     <= 1'b0;
               r_addr   <= {ADDR_W{1'b0}};
               r_wdata  <= {LINE_W{1'b0}};
            end
            default: begin
               r_state  <= IDLE;
               r_cnt    <= 4'd0;
               r_ic_ack <= 1'b0;
               r_dc_ack <= 1'b0;
               r_mem_we <= 1'b0;
               r_busy   <= 1'b0;
               r_we     <= 1'b0;
               r_addr   <= {ADDR_W{1'b0}};
               r_wdata  <= {LINE_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed tests.
module tb_mem_arbiter;

   localparam int L = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, ic_req, dc_req, dc_we;
   logic [25:0]  ic_addr, dc_addr, mem_addr, mem_waddr;
   logic [127:0] dc_wdata, ic_rdata, dc_rdata, mem_wdata, mem_rdata;
   logic         ic_ack, dc_ack, mem_reset, mem_we, busy;

   logic         ic1_req, dc1_req, dc1_we;
   logic [25:0]  ic1_addr, dc1_addr, mem1_addr, mem1_waddr;
   logic [127:0] dc1_wdata, ic1_rdata, dc1_rdata, mem1_wdata, mem1_rdata;
   logic         ic1_ack, dc1_ack, mem1_reset, mem1_we, busy1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   mem_arbiter dut (
      .clk(clk), .reset(reset), .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
      .ic_rdata(ic_rdata), .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
      .dc_wdata(dc_wdata), .dc_ack(dc_ack), .dc_rdata(dc_rdata), .mem_reset(mem_reset),
      .mem_addr(mem_addr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.MEM_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .ic_req(ic1_req), .ic_addr(ic1_addr), .ic_ack(ic1_ack),
      .ic_rdata(ic1_rdata), .dc_req(dc1_req), .dc_we(dc1_we), .dc_addr(dc1_addr),
      .dc_wdata(dc1_wdata), .dc_ack(dc1_ack), .dc_rdata(dc1_rdata), .mem_reset(mem1_reset),
      .mem_addr(mem1_addr), .mem_waddr(mem1_waddr), .mem_wdata(mem1_wdata), .mem_we(mem1_we),
      .mem_rdata(mem1_rdata), .busy(busy1)
   );

   // RAM of 32-bit words; a line holds four words, highest word in the top bits.
   function automatic logic [127:0] init_line(input logic [25:0] a);
      logic [31:0] b;
      b = 32'h1000_0000 + {4'd0, a, 2'b00};
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   logic [127:0] env_ram [logic [25:0]];
   logic [127:0] mdl_ram [logic [25:0]];
   int ram_gen = 0;

   function automatic logic [127:0] rd_env(input logic [25:0] a);
      if (env_ram.exists(a)) return env_ram[a];
      return init_line(a);
   endfunction

   function automatic logic [127:0] mdl_line(input logic [25:0] a);
      if (mdl_ram.exists(a)) return mdl_ram[a];
      return init_line(a);
   endfunction

   // Environment RAM: combinational read, writes land at the clock edge.
   always @(mem_addr or ram_gen) mem_rdata = rd_env(mem_addr);
   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         env_ram[mem_waddr] = mem_wdata;
         ram_gen++;
      end
   end
   assign mem1_rdata = init_line(mem1_addr);

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // Transaction-level model: a grant at cycle g occupies g+1..g+L+1, ack at g+L+1.
   bit           m_act = 1'b0;
   int           m_g = 0;
   bit           m_dc = 1'b0;
   bit           m_we = 1'b0;
   bit           m_last_dc = 1'b1;
   logic [25:0]  m_addr = '0;
   logic [127:0] m_wdata = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_act = 1'b0;
         m_last_dc = 1'b1;
      end else begin
         if (m_act && cyc == m_g + L + 1 && m_we) mdl_ram[m_addr] = m_wdata;
         if ((!m_act || cyc >= m_g + L + 2) && (ic_req || dc_req)) begin
            m_dc = (ic_req && dc_req) ? !m_last_dc : dc_req;
            m_last_dc = m_dc;
            m_act = 1'b1;
            m_g = cyc;
            m_addr = m_dc ? dc_addr : ic_addr;
            m_we = m_dc ? dc_we : 1'b0;
            m_wdata = m_dc ? dc_wdata : 128'd0;
         end
      end
      cyc++;
   end

   logic         e_busy, e_ica, e_dca, e_we;
   logic [25:0]  e_addr;
   logic [127:0] e_wd, e_icr, e_dcr;
   int           we_cnt = 0;
   int           busy1_cnt = 0;

   // Compare every cycle against the model, away from the active edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1) we_cnt++;
      if (busy1 === 1'b1) busy1_cnt++;
      if (cyc >= 1) begin
         e_busy = 1'b0; e_ica = 1'b0; e_dca = 1'b0; e_we = 1'b0;
         e_addr = '0; e_wd = '0; e_icr = '0; e_dcr = '0;
         if (!reset && m_act && cyc > m_g && cyc <= m_g + L + 1) begin
            e_busy = 1'b1;
            e_addr = m_addr;
            e_wd = m_wdata;
            if (cyc == m_g + L + 1) begin
               e_we = m_we;
               if (m_dc) begin
                  e_dca = 1'b1;
                  if (!m_we) e_dcr = mdl_line(m_addr);
               end else begin
                  e_ica = 1'b1;
                  e_icr = mdl_line(m_addr);
               end
            end
         end
         chk("busy", 128'(busy), 128'(e_busy));
         chk("ic_ack", 128'(ic_ack), 128'(e_ica));
         chk("dc_ack", 128'(dc_ack), 128'(e_dca));
         chk("ack_overlap", 128'(ic_ack & dc_ack), 128'd0);
         chk("mem_we", 128'(mem_we), 128'(e_we));
         chk("mem_addr", 128'(mem_addr), 128'(e_addr));
         chk("mem_waddr", 128'(mem_waddr), 128'(e_addr));
         chk("mem_wdata", mem_wdata, e_wd);
         chk("ic_rdata", ic_rdata, e_icr);
         chk("dc_rdata", dc_rdata, e_dcr);
         chk("mem_reset", 128'(mem_reset), 128'(reset));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ack(input bit want_dc, output int at);
      at = -1;
      for (int k = 0; k < 40; k++) begin
         step();
         if ((want_dc ? dc_ack : ic_ack) === 1'b1) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout cyc=%0d got=none expected=ack", cyc);
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   int r, a, ai, ad, n, w0, b0;
   int who [4];
   int when [4];
   bit seen;
   logic [127:0] cap;

   initial begin
      reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
      ic_addr = '0; dc_addr = '0; dc_wdata = '0;
      ic1_req = 1'b0; dc1_req = 1'b0; dc1_we = 1'b0;
      ic1_addr = '0; dc1_addr = '0; dc1_wdata = '0;
      repeat (3) step();
      chk("rst_busy_during", 128'(busy), 128'd0);
      reset = 1'b0;
      step();
      chk("rst_busy_after", 128'(busy), 128'd0);
      chk("rst_addr_after", 128'(mem_addr), 128'd0);

      // Boot line fetch.
      ic_addr = 26'h400; ic_req = 1'b1; r = cyc;
      wait_ack(1'b0, a);
      chk("boot_lat", 128'(a - r), 128'd6);
      chk("boot_data", ic_rdata, {32'h10001003, 32'h10001002, 32'h10001001, 32'h10001000});
      ic_req = 1'b0; ic_addr = '0;
      step();

      // Data write, request and inputs dropped mid-transaction.
      dc_we = 1'b1; dc_addr = 26'h10; dc_wdata = {16{8'hA5}}; dc_req = 1'b1; r = cyc; w0 = we_cnt;
      step(); step();
      dc_req = 1'b0; dc_addr = 26'h3FF; dc_wdata = '0; dc_we = 1'b0;
      wait_ack(1'b1, a);
      chk("wr_lat", 128'(a - r), 128'd6);
      chk("wr_we", 128'(mem_we), 128'd1);
      chk("wr_waddr", 128'(mem_waddr), 128'h10);
      step();
      chk("wr_count", 128'(we_cnt - w0), 128'd1);

      // Read back the written line.
      dc_we = 1'b0; dc_addr = 26'h10; dc_req = 1'b1;
      wait_ack(1'b1, a);
      chk("rd_data", dc_rdata, {16{8'hA5}});
      dc_req = 1'b0;
      step();

      // Simultaneous requests straight after reset.
      reset = 1'b1; step(); step(); reset = 1'b0; step();
      ic_addr = 26'h21; dc_addr = 26'h22; dc_we = 1'b0; ic_req = 1'b1; dc_req = 1'b1; r = cyc;
      ai = -100; ad = -100;
      for (int k = 0; k < 40; k++) begin
         step();
         if (ic_ack === 1'b1) begin ai = cyc; ic_req = 1'b0; end
         if (dc_ack === 1'b1) begin ad = cyc; dc_req = 1'b0; break; end
      end
      chk("tie_ic_lat", 128'(ai - r), 128'd6);
      chk("tie_dc_lat", 128'(ad - r), 128'd13);
      step();

      // Both held for four transactions, addresses churning every cycle.
      ic_req = 1'b1; dc_req = 1'b1; n = 0;
      for (int k = 0; k < 80 && n < 4; k++) begin
         step();
         ic_addr = 26'(cyc * 3);
         dc_addr = 26'(cyc * 5 + 1);
         if (ic_ack === 1'b1) begin who[n] = 0; when[n] = cyc; n++; end
         else if (dc_ack === 1'b1) begin who[n] = 1; when[n] = cyc; n++; end
      end
      ic_req = 1'b0; dc_req = 1'b0;
      chk("rr_count", 128'(n), 128'd4);
      for (int i = 0; i < 4; i++) chk("rr_order", 128'(who[i]), 128'(i % 2));
      for (int i = 1; i < 4; i++) chk("rr_gap", 128'(when[i] - when[i-1]), 128'd7);
      step();

      // Reset during the WAIT of a write abandons it.
      dc_we = 1'b1; dc_addr = 26'h20; dc_wdata = {4{32'hDEADBEEF}}; dc_req = 1'b1; w0 = we_cnt; seen = 1'b0;
      step(); step(); step();
      reset = 1'b1; dc_req = 1'b0; dc_we = 1'b0;
      step();
      if (dc_ack === 1'b1) seen = 1'b1;
      reset = 1'b0;
      step();
      chk("abort_busy", 128'(busy), 128'd0);
      for (int k = 0; k < 12; k++) begin
         if (dc_ack === 1'b1) seen = 1'b1;
         step();
      end
      chk("abort_ack", 128'(seen), 128'd0);
      chk("abort_we", 128'(we_cnt - w0), 128'd0);
      dc_we = 1'b0; dc_addr = 26'h20; dc_req = 1'b1;
      wait_ack(1'b1, a);
      chk("abort_rd", dc_rdata, {32'h10000083, 32'h10000082, 32'h10000081, 32'h10000080});
      dc_req = 1'b0;
      step();

      // Minimum latency instance.
      ic1_addr = 26'h400; ic1_req = 1'b1; r = cyc; b0 = busy1_cnt; a = -100; cap = '0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (ic1_ack === 1'b1) begin a = cyc; cap = ic1_rdata; ic1_req = 1'b0; break; end
      end
      step(); step();
      chk("l1_lat", 128'(a - r), 128'd2);
      chk("l1_busy", 128'(busy1_cnt - b0), 128'd2);
      chk("l1_data", cap, {32'h10001003, 32'h10001002, 32'h10001001, 32'h10001000});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
